// File: rtl/motor_pkg.sv
// motor_pkg: shared state encoding and direction constants for motor_seq
package motor_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DEAD   = 3'd1,
    RUN_UP = 3'd2,
    RUN_DN = 3'd3,
    FAULT  = 3'd4
  } state_t;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;
endpackage

// File: rtl/motor_timer.sv
// motor_timer: loadable down-counter shared by dead-time and travel timeout
module motor_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - CNT_W'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/motor_seq.sv
// motor_seq: up/down motor sequencer with dead-time, auto-reverse and latched fault
module motor_seq
  import motor_pkg::*;
#(
  parameter int DEAD_TIME  = 8,
  parameter int TRAVEL_MAX = 50000,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_open,
  input  logic cmd_close,
  input  logic cmd_stop,
  input  logic up_limit,
  input  logic dn_limit,
  input  logic obstruct,
  output logic motor_up,
  output logic motor_dn,
  output logic busy,
  output logic fault
);
  state_t           state, nxt;
  logic             dir, dir_nxt;
  logic             up_d, dn_d, fault_d;
  logic             load, zero;
  logic [CNT_W-1:0] load_val;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state    <= IDLE;
      dir      <= DIR_UP;
      motor_up <= 1'b0;
      motor_dn <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= nxt;
      dir      <= dir_nxt;
      motor_up <= up_d;
      motor_dn <= dn_d;
      fault    <= fault_d;
    end
  always_comb begin
    nxt     = state;
    dir_nxt = dir;
    if (state != FAULT && up_limit && dn_limit) nxt = FAULT;
    else
      case (state)
        IDLE:
          if (!cmd_stop && !(cmd_open && cmd_close)) begin
            if (cmd_open && !up_limit) begin
              nxt     = DEAD;
              dir_nxt = DIR_UP;
            end else if (cmd_close && !dn_limit) begin
              nxt     = DEAD;
              dir_nxt = DIR_DN;
            end
          end
        DEAD:
          if (cmd_stop) nxt = IDLE;
          else if (zero) nxt = dir == DIR_UP ? RUN_UP : RUN_DN;
        RUN_UP:
          if (cmd_stop || up_limit) nxt = IDLE;
          else if (zero) nxt = FAULT;
          else if (cmd_close) begin
            nxt     = DEAD;
            dir_nxt = DIR_DN;
          end
        RUN_DN:
          if (cmd_stop) nxt = IDLE;
          else if (obstruct) begin
            nxt     = DEAD;
            dir_nxt = DIR_UP;
          end else if (dn_limit) nxt = IDLE;
          else if (zero) nxt = FAULT;
          else if (cmd_open) begin
            nxt     = DEAD;
            dir_nxt = DIR_UP;
          end
        FAULT:
          if (cmd_stop && !(up_limit && dn_limit)) nxt = IDLE;
        default: nxt = IDLE;
      endcase
  end
  always_comb begin
    up_d     = nxt == RUN_UP;
    dn_d     = nxt == RUN_DN;
    fault_d  = nxt == FAULT;
    load     = nxt != state && (nxt == DEAD || nxt == RUN_UP || nxt == RUN_DN);
    load_val = nxt == DEAD ? CNT_W'(DEAD_TIME - 1) : CNT_W'(TRAVEL_MAX - 1);
  end
  assign busy = state == DEAD || state == RUN_UP || state == RUN_DN;
  motor_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .en      (busy),
    .load_val(load_val),
    .zero    (zero)
  );
endmodule
